// File: rtl/svc_uart_rx.sv
// svc_uart_rx: 8N1 UART receiver with mid-bit sampling,
// break detection and a one-deep valid/ready output buffer.
module svc_uart_rx #(
  parameter int CLOCK_FREQ = 25_000_000,
  parameter int BAUD_RATE  = 115_200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       urx_pin,
  output logic       urx_valid,
  output logic [7:0] urx_data,
  input  logic       urx_ready,
  output logic       urx_frame_err,
  output logic       urx_overrun
);

  localparam int CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CW = $clog2(CLKS_PER_BIT + 1);

  localparam logic [CW-1:0] BIT_LOAD =
    CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LOAD =
    CW'((HALF_BIT > 0) ? HALF_BIT - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_e;

  logic          sync1_q, sync2_q;
  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          valid_q, valid_d;
  logic [7:0]    data_q, data_d;
  logic          ferr_q, ferr_d;
  logic          ovr_q, ovr_d;
  logic          rx;
  logic          tick;
  logic          deliver;

  assign rx   = sync2_q;
  assign tick = (cnt_q == '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    deliver = 1'b0;
    ferr_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!rx) begin
          cnt_d   = HALF_LOAD;
          state_d = S_START;
        end
      end
      S_START: begin
        if (!tick) begin
          cnt_d = cnt_q - 1'b1;
        end else if (!rx) begin
          cnt_d   = BIT_LOAD;
          idx_d   = 3'd0;
          state_d = S_DATA;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_DATA: begin
        if (!tick) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          shift_d = {rx, shift_q[7:1]};
          cnt_d   = BIT_LOAD;
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
            state_d = S_STOP;
          end
        end
      end
      S_STOP: begin
        if (!tick) begin
          cnt_d = cnt_q - 1'b1;
        end else if (rx) begin
          deliver = 1'b1;
          state_d = S_IDLE;
        end else begin
          ferr_d  = 1'b1;
          state_d = S_BREAK;
        end
      end
      S_BREAK: begin
        if (rx) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output buffer never back-pressures the receiver.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    ovr_d   = 1'b0;
    if (valid_q && urx_ready) begin
      valid_d = 1'b0;
    end
    if (deliver) begin
      if (valid_q && !urx_ready) begin
        ovr_d = 1'b1;
      end else begin
        valid_d = 1'b1;
        data_d  = shift_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= 3'd0;
      shift_q <= 8'h00;
      valid_q <= 1'b0;
      data_q  <= 8'h00;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      sync1_q <= urx_pin;
      sync2_q <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  assign urx_valid     = valid_q;
  assign urx_data      = data_q;
  assign urx_frame_err = ferr_q;
  assign urx_overrun   = ovr_q;

endmodule

// File: doc/svc_uart_rx.md
SVC_UART_RX -- requirements
Module: svc_uart_rx

Interface
REQ-001 SHALL have parameter CLOCK_FREQ, default 25_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 115_200, serial bit rate.
REQ-003 SHALL derive localparam CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE (integer truncation; 217 at defaults) and HALF_BIT = CLKS_PER_BIT / 2.
REQ-004 SHALL have port clk  input  1  sole clock; all state on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have port urx_pin  input  1  asynchronous serial line, idle high.
REQ-007 SHALL have port urx_valid  output  1  received byte available.
REQ-008 SHALL have port urx_data  output  8  received byte, LSB-first reassembled.
REQ-009 SHALL have port urx_ready  input  1  consumer accepts byte.
REQ-010 SHALL have port urx_frame_err  output  1  one-cycle pulse: stop bit sampled low.
REQ-011 SHALL have port urx_overrun  output  1  one-cycle pulse: byte dropped, output still held.

Function
REQ-012 SHALL pass urx_pin through a 2-flop synchronizer (reset value 1) before any use.
REQ-013 SHALL implement FSM states IDLE, START, DATA, STOP, BREAK, with a bit-period counter and 3-bit bit index.
REQ-014 IDLE: synchronized line low SHALL load counter and enter START.
REQ-015 START: after HALF_BIT cycles, line low -> DATA with counter reloaded to CLKS_PER_BIT; line high -> IDLE (glitch rejected, no pulse).
REQ-016 DATA: every CLKS_PER_BIT cycles SHALL sample one bit into shift register bit index 0..7 (LSB first); after bit 7 -> STOP.
REQ-017 STOP: after CLKS_PER_BIT cycles, line high -> deliver byte, go IDLE; line low -> pulse urx_frame_err, discard byte, go BREAK.
REQ-018 BREAK: SHALL remain until synchronized line is high, then IDLE; no start detected while in BREAK.
REQ-019 Delivery SHALL set urx_valid=1 and urx_data=byte on the cycle after the stop-bit sample.
REQ-020 urx_valid and urx_data SHALL hold stable until a cycle with urx_valid && urx_ready; urx_valid then clears next edge.
REQ-021 Delivery while urx_valid && !urx_ready SHALL drop the new byte, keep the old urx_data, and pulse urx_overrun for one cycle.
REQ-022 Delivery in the same cycle as urx_valid && urx_ready SHALL load the new byte, keep urx_valid=1, no overrun.
REQ-023 urx_ready while urx_valid=0 SHALL have no effect.
REQ-024 Receiver FSM SHALL never stall on the output handshake; reception continues regardless of urx_ready.
REQ-025 End-to-end latency from start-bit falling edge at urx_pin to urx_valid SHALL be 2 + HALF_BIT + 9*CLKS_PER_BIT + 1 cycles (+-1 for edge alignment).

Reset
REQ-026 rst_n low SHALL immediately force: FSM IDLE, counters 0, synchronizer 1s, urx_valid 0, urx_data 0, urx_frame_err 0, urx_overrun 0.
REQ-027 Reset asserted mid-frame SHALL abandon the frame; after release, receiver waits for a new falling edge, no partial byte delivered.
REQ-028 Outputs SHALL be defined (no X) from the first edge after reset release.

Verification
REQ-029 Bench SHALL use CLOCK_FREQ=8, BAUD_RATE=1 (CLKS_PER_BIT=8, HALF_BIT=4) for directed tests, plus one defaults smoke test.
REQ-030 Send 0xA5 with urx_ready=1 -> single-cycle urx_valid with urx_data=0xA5, no error pulses.
REQ-031 Send 0x3C, 0x81 with urx_ready=0 -> urx_data stays 0x3C, urx_overrun pulses once at second delivery; raising urx_ready then clears urx_valid.
REQ-032 Send 0x55 with stop bit driven low, then line high -> urx_frame_err single pulse, urx_valid stays 0; next frame 0x12 received correctly.
REQ-033 Low glitch of 2 cycles on idle line -> no urx_valid, no error, FSM back to IDLE; following frame 0xFF received.
REQ-034 Assert rst_n low during DATA bit 4 of 0xC3, release, send 0x7E -> only 0x7E delivered.
REQ-035 Back-to-back frames 0x01, 0x02 with urx_ready pulsed exactly on second delivery cycle -> both bytes observed in order, no urx_overrun.
